// File: rtl/dsi_pkg.sv
// Shared types for the DSI HS burst controller: FSM state encoding and lane limits.
package dsi_pkg;

  localparam int unsigned DSI_MAX_LANES = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLK_GO,
    ST_CLK_PRE,
    ST_DL_GO,
    ST_SEND,
    ST_DL_TRAIL,
    ST_CLK_POST,
    ST_CLK_FIN,
    ST_CLK_HOLD
  } burst_state_t;

  // Byte count of a final beat; 0 or anything above the lane count means a full beat.
  function automatic logic [2:0] eff_bytes(input logic [2:0] bytes, input int unsigned lanes);
    if (bytes == 3'd0 || 32'(bytes) > lanes) return 3'(lanes);
    return bytes;
  endfunction

endpackage

// File: rtl/dsi_hs_burst_ctrl_if.sv
// Byte-striped packet stream from the packet assembler into the burst controller.
interface dsi_hs_burst_ctrl_if #(parameter int unsigned LANES = 4);

  logic [8*LANES-1:0] in_data;
  logic               in_valid;
  logic               in_last;
  logic [2:0]         in_bytes;
  logic               in_ready;

  modport master (output in_data, in_valid, in_last, in_bytes, input in_ready);
  modport slave  (input in_data, in_valid, in_last, in_bytes, output in_ready);

endinterface

// File: rtl/dsi_timeout_cnt.sv
// 8-bit load/countdown timer; 'expired' marks the last cycle of a loaded interval (0 acts as 1).
module dsi_timeout_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: next-state defaults to the current value first, so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (load)                         cnt_d = load_val;
    else if (dec && cnt_q != 8'd0)    cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q <= 8'd1);

endmodule

// File: rtl/dsi_hs_burst_ctrl.sv
// HS burst sequencer: clock lane up, data lanes up, byte distribution, trail, clock post and LP gap.
module dsi_hs_burst_ctrl
  import dsi_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  dsi_hs_burst_ctrl_if.slave s_if,
  input  logic               clk_continuous,
  input  logic [7:0]         clk_pre_timeout,
  input  logic [7:0]         clk_post_timeout,
  input  logic [7:0]         lp_gap_timeout,
  output logic               clk_start_rqst,
  output logic               clk_fin_rqst,
  input  logic               clk_active,
  input  logic               clk_fin_ack,
  output logic [LANES-1:0]   dl_start_rqst,
  output logic [LANES-1:0]   dl_fin_rqst,
  output logic [8*LANES-1:0] dl_data,
  input  logic [LANES-1:0]   dl_data_rqst,
  input  logic [LANES-1:0]   dl_fin_ack,
  output logic               busy,
  output logic               underrun
);

  burst_state_t       state_q, state_d;
  logic               clk_start_rqst_q, clk_start_rqst_d;
  logic               clk_fin_rqst_q, clk_fin_rqst_d;
  logic [LANES-1:0]   dl_start_rqst_q, dl_start_rqst_d;
  logic [LANES-1:0]   dl_fin_rqst_q, dl_fin_rqst_d;
  logic [8*LANES-1:0] dl_data_q, dl_data_d;
  logic [LANES-1:0]   done_mask_q, done_mask_d;
  logic               busy_q, busy_d;
  logic               underrun_q, underrun_d;

  logic       pre_load, post_load, gap_load;
  logic       pre_expired, post_expired, gap_expired;
  logic       all_rqst;
  logic [2:0] n_bytes;

  assign all_rqst      = &dl_data_rqst;
  assign n_bytes       = eff_bytes(s_if.in_bytes, LANES);
  assign s_if.in_ready = (state_q == ST_SEND) && all_rqst;

  dsi_timeout_cnt u_pre_cnt (
    .clk(clk), .rst(rst), .load(pre_load), .load_val(clk_pre_timeout),
    .dec(state_q == ST_CLK_PRE), .expired(pre_expired)
  );

  dsi_timeout_cnt u_post_cnt (
    .clk(clk), .rst(rst), .load(post_load), .load_val(clk_post_timeout),
    .dec(state_q == ST_CLK_POST), .expired(post_expired)
  );

  dsi_timeout_cnt u_gap_cnt (
    .clk(clk), .rst(rst), .load(gap_load), .load_val(lp_gap_timeout),
    .dec(state_q == ST_IDLE), .expired(gap_expired)
  );

  always_comb begin
    state_d          = state_q;
    clk_start_rqst_d = 1'b0;
    clk_fin_rqst_d   = 1'b0;
    dl_start_rqst_d  = '0;
    dl_fin_rqst_d    = '0;
    dl_data_d        = dl_data_q;
    done_mask_d      = done_mask_q;
    underrun_d       = 1'b0;
    pre_load         = 1'b0;
    post_load        = 1'b0;
    gap_load         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (s_if.in_valid && gap_expired) begin
          state_d          = ST_CLK_GO;
          clk_start_rqst_d = 1'b1;
        end
      end
      ST_CLK_GO: begin
        if (clk_active) begin
          state_d  = ST_CLK_PRE;
          pre_load = 1'b1;
        end
      end
      ST_CLK_PRE: begin
        if (pre_expired) begin
          state_d         = ST_DL_GO;
          dl_start_rqst_d = '1;
        end
      end
      ST_DL_GO: begin
        if (all_rqst) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (all_rqst) begin
          if (s_if.in_valid) begin
            // Short final beat: upper lanes keep their previous byte and only see fin_rqst.
            for (int i = 0; i < int'(LANES); i++) begin
              if (!s_if.in_last || i < int'(n_bytes))
                dl_data_d[8*i +: 8] = s_if.in_data[8*i +: 8];
            end
            if (s_if.in_last) begin
              dl_fin_rqst_d = '1;
              done_mask_d   = '0;
              state_d       = ST_DL_TRAIL;
            end
          end else begin
            underrun_d = 1'b1;
            dl_data_d  = '0;
          end
        end
      end
      ST_DL_TRAIL: begin
        done_mask_d = done_mask_q | dl_fin_ack;
        if (&done_mask_d) begin
          state_d   = ST_CLK_POST;
          post_load = 1'b1;
        end
      end
      ST_CLK_POST: begin
        if (post_expired) begin
          if (clk_continuous) begin
            state_d = ST_CLK_HOLD;
          end else begin
            state_d        = ST_CLK_FIN;
            clk_fin_rqst_d = 1'b1;
          end
        end
      end
      ST_CLK_FIN: begin
        if (clk_fin_ack) begin
          state_d  = ST_IDLE;
          gap_load = 1'b1;
        end else begin
          clk_fin_rqst_d = 1'b1;
        end
      end
      ST_CLK_HOLD: begin
        if (s_if.in_valid) begin
          state_d  = ST_CLK_PRE;
          pre_load = 1'b1;
        end else if (!clk_continuous) begin
          state_d        = ST_CLK_FIN;
          clk_fin_rqst_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = !(state_d inside {ST_IDLE, ST_CLK_HOLD});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      clk_start_rqst_q <= 1'b0;
      clk_fin_rqst_q   <= 1'b0;
      dl_start_rqst_q  <= '0;
      dl_fin_rqst_q    <= '0;
      dl_data_q        <= '0;
      done_mask_q      <= '0;
      busy_q           <= 1'b0;
      underrun_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      clk_start_rqst_q <= clk_start_rqst_d;
      clk_fin_rqst_q   <= clk_fin_rqst_d;
      dl_start_rqst_q  <= dl_start_rqst_d;
      dl_fin_rqst_q    <= dl_fin_rqst_d;
      dl_data_q        <= dl_data_d;
      done_mask_q      <= done_mask_d;
      busy_q           <= busy_d;
      underrun_q       <= underrun_d;
    end
  end

  assign clk_start_rqst = clk_start_rqst_q;
  assign clk_fin_rqst   = clk_fin_rqst_q;
  assign dl_start_rqst  = dl_start_rqst_q;
  assign dl_fin_rqst    = dl_fin_rqst_q;
  assign dl_data        = dl_data_q;
  assign busy           = busy_q;
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_dsi_hs_burst_ctrl.sv
// Directed bench for dsi_hs_burst_ctrl: lane handshakes are driven by hand, cycle by cycle.
module tb_dsi_hs_burst_ctrl;

  localparam int LANES = 4;
  localparam int W_CLK_START = 0;
  localparam int W_DL_START  = 1;
  localparam int W_CLK_FIN   = 2;
  localparam int W_BUSY_LOW  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dsi_hs_burst_ctrl_if #(.LANES(LANES)) s_if ();

  logic             clk_continuous;
  logic [7:0]       pre_t, post_t, gap_t;
  logic             clk_start_rqst, clk_fin_rqst, clk_active, clk_fin_ack;
  logic [LANES-1:0] dl_start_rqst, dl_fin_rqst, dl_data_rqst, dl_fin_ack;
  logic [31:0]      dl_data;
  logic             busy, underrun;

  dsi_hs_burst_ctrl #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .s_if(s_if),
    .clk_continuous(clk_continuous),
    .clk_pre_timeout(pre_t), .clk_post_timeout(post_t), .lp_gap_timeout(gap_t),
    .clk_start_rqst(clk_start_rqst), .clk_fin_rqst(clk_fin_rqst),
    .clk_active(clk_active), .clk_fin_ack(clk_fin_ack),
    .dl_start_rqst(dl_start_rqst), .dl_fin_rqst(dl_fin_rqst), .dl_data(dl_data),
    .dl_data_rqst(dl_data_rqst), .dl_fin_ack(dl_fin_ack),
    .busy(busy), .underrun(underrun)
  );

  int errors = 0;
  int checks = 0;
  int clk_start_pulses = 0;
  logic [31:0] last_word = '0;

  always @(negedge clk) begin
    if (clk_start_rqst) clk_start_pulses <= clk_start_pulses + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input int which);
    case (which)
      W_CLK_START: return clk_start_rqst;
      W_DL_START:  return dl_start_rqst != '0;
      W_CLK_FIN:   return clk_fin_rqst;
      default:     return !busy;
    endcase
  endfunction

  // Ticks until the selected condition holds; n = cycles taken, or -1 when the bound runs out.
  task automatic wait_for(input int which, input int limit, output int n);
    bit found = 1'b0;
    n = 0;
    while (!found && n < limit) begin
      tick();
      n++;
      found = cond(which);
    end
    if (!found) n = -1;
  endtask

  function automatic logic [31:0] beat_word(input int id, input int b);
    logic [31:0] w;
    for (int i = 0; i < LANES; i++) w[8*i +: 8] = 8'(id * 16 + b * 4 + i);
    return w;
  endfunction

  task automatic present(input int id, input int b, input logic last, input logic [2:0] bytes);
    s_if.in_valid = 1'b1;
    s_if.in_data  = beat_word(id, b);
    s_if.in_last  = last;
    s_if.in_bytes = bytes;
  endtask

  task automatic clk_bringup(output int n);
    wait_for(W_CLK_START, 40, n);
    tick();
    check("clk_start_one_cycle", {31'd0, clk_start_rqst}, 32'd0);
    check("busy_in_clk_go", {31'd0, busy}, 32'd1);
    clk_active = 1'b1;
  endtask

  task automatic pre_and_go(input int exp_n);
    int n;
    wait_for(W_DL_START, 40, n);
    check("pre_length", n, exp_n);
    check("dl_start_all", {28'd0, dl_start_rqst}, 32'hF);
    check("ready_low_dl_go", {31'd0, s_if.in_ready}, 32'd0);
    tick();
    check("dl_start_one_cycle", {28'd0, dl_start_rqst}, 32'd0);
    dl_data_rqst = '1;
    #1;
    check("ready_low_before_send", {31'd0, s_if.in_ready}, 32'd0);
    tick();
    check("ready_in_send", {31'd0, s_if.in_ready}, 32'd1);
  endtask

  task automatic send_beats(input int id, input int nbeats, input logic [2:0] bytes, input int gap_at);
    logic [31:0] exp;
    int eff;
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < 2; g++) begin
          s_if.in_valid = 1'b0;
          tick();
          check("underrun_pulse", {31'd0, underrun}, 32'd1);
          check("underrun_data_zero", dl_data, 32'd0);
          check("ready_during_underrun", {31'd0, s_if.in_ready}, 32'd1);
          last_word = '0;
        end
      end
      present(id, b, b == nbeats - 1, bytes);
      tick();
      exp = beat_word(id, b);
      if (b == nbeats - 1) begin
        eff = (bytes == 3'd0 || int'(bytes) > LANES) ? LANES : int'(bytes);
        for (int i = eff; i < LANES; i++) exp[8*i +: 8] = last_word[8*i +: 8];
      end
      check("dl_data_beat", dl_data, exp);
      check("no_underrun_on_beat", {31'd0, underrun}, 32'd0);
      check("dl_fin_on_beat", {28'd0, dl_fin_rqst}, (b == nbeats - 1) ? 32'hF : 32'h0);
      last_word = exp;
    end
    s_if.in_valid = 1'b0;
    s_if.in_last  = 1'b0;
    #1;
    check("ready_low_trail", {31'd0, s_if.in_ready}, 32'd0);
    dl_data_rqst = '0;
    tick();
    check("dl_fin_one_cycle", {28'd0, dl_fin_rqst}, 32'd0);
    check("dl_data_held_after_fin", dl_data, last_word);
  endtask

  task automatic trail_post(input bit stagger, input int exp_post, input bit expect_fin);
    int n;
    if (stagger) begin
      dl_fin_ack = 4'b0001;
      tick();
      dl_fin_ack = 4'b0010;
      tick();
      dl_fin_ack = 4'b0000;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("trail_waits_busy", {31'd0, busy}, 32'd1);
        check("trail_waits_no_fin", {31'd0, clk_fin_rqst}, 32'd0);
      end
      dl_fin_ack = 4'b1100;
    end else begin
      dl_fin_ack = 4'b1111;
    end
    tick();
    dl_fin_ack = '0;
    wait_for(expect_fin ? W_CLK_FIN : W_BUSY_LOW, 40, n);
    check("post_length", n, exp_post);
    if (expect_fin) begin
      check("busy_in_clk_fin", {31'd0, busy}, 32'd1);
      tick();
      check("clk_fin_held", {31'd0, clk_fin_rqst}, 32'd1);
      clk_fin_ack = 1'b1;
      clk_active  = 1'b0;
      tick();
      clk_fin_ack = 1'b0;
      check("clk_fin_released", {31'd0, clk_fin_rqst}, 32'd0);
      check("busy_low_idle", {31'd0, busy}, 32'd0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        check("hold_no_clk_fin", {31'd0, clk_fin_rqst}, 32'd0);
        check("hold_not_busy", {31'd0, busy}, 32'd0);
        tick();
      end
    end
  endtask

  initial begin
    int n;
    int starts_before;

    rst            = 1'b1;
    clk_continuous = 1'b0;
    pre_t          = 8'd3;
    post_t         = 8'd2;
    gap_t          = 8'd4;
    clk_active     = 1'b0;
    clk_fin_ack    = 1'b0;
    dl_data_rqst   = '0;
    dl_fin_ack     = '0;
    s_if.in_valid  = 1'b0;
    s_if.in_data   = '0;
    s_if.in_last   = 1'b0;
    s_if.in_bytes  = 3'd0;

    tick();
    tick();
    check("rst_clk_start", {31'd0, clk_start_rqst}, 32'd0);
    check("rst_clk_fin", {31'd0, clk_fin_rqst}, 32'd0);
    check("rst_dl_start", {28'd0, dl_start_rqst}, 32'd0);
    check("rst_dl_fin", {28'd0, dl_fin_rqst}, 32'd0);
    check("rst_dl_data", dl_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_ready", {31'd0, s_if.in_ready}, 32'd0);
    rst = 1'b0;

    // T1: basic two-beat burst, full last beat
    present(1, 0, 1'b0, 3'd4);
    clk_bringup(n);
    check("t1_first_start_undelayed", n, 1);
    pre_and_go(4);
    send_beats(1, 2, 3'd4, -1);
    trail_post(1'b0, 2, 1'b1);
    check("t1_one_clk_start", clk_start_pulses, 1);

    // T2 + T5: back-to-back burst, short last beat, staggered fin_ack
    present(2, 0, 1'b0, 3'd1);
    clk_bringup(n);
    check("t5_gap_min", {31'd0, n >= 4}, 32'd1);
    check("t5_gap_max", {31'd0, n <= 5}, 32'd1);
    pre_and_go(4);
    send_beats(2, 3, 3'd1, -1);
    trail_post(1'b1, 2, 1'b1);

    // T3: two-cycle underrun mid-burst, pre timeout 0, in_bytes 0 on last beat
    pre_t = 8'd0;
    present(3, 0, 1'b0, 3'd0);
    clk_bringup(n);
    check("t3_gap_min", {31'd0, n >= 4}, 32'd1);
    pre_and_go(2);
    send_beats(3, 4, 3'd0, 2);
    trail_post(1'b0, 2, 1'b1);
    check("t3_clk_start_count", clk_start_pulses, 3);

    // T4: continuous clock, second burst restarts from CLK_HOLD
    pre_t          = 8'd3;
    clk_continuous = 1'b1;
    present(4, 0, 1'b0, 3'd4);
    clk_bringup(n);
    pre_and_go(4);
    send_beats(4, 2, 3'd4, -1);
    trail_post(1'b0, 2, 1'b0);
    starts_before = clk_start_pulses;
    present(5, 0, 1'b1, 3'd2);
    pre_and_go(4);
    clk_continuous = 1'b0;
    send_beats(5, 1, 3'd2, -1);
    trail_post(1'b0, 2, 1'b1);
    check("t4_no_restart_from_hold", clk_start_pulses, starts_before);

    // T6: reset in SEND, then a clean burst
    present(6, 0, 1'b0, 3'd4);
    clk_bringup(n);
    pre_and_go(4);
    tick();
    check("t6_beat_before_rst", dl_data, beat_word(6, 0));
    rst = 1'b1;
    #1;
    check("t6_rst_dl_data", dl_data, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_ready", {31'd0, s_if.in_ready}, 32'd0);
    check("t6_rst_clk_start", {31'd0, clk_start_rqst}, 32'd0);
    check("t6_rst_dl_fin", {28'd0, dl_fin_rqst}, 32'd0);
    tick();
    clk_active    = 1'b0;
    dl_data_rqst  = '0;
    dl_fin_ack    = '0;
    s_if.in_valid = 1'b0;
    last_word     = '0;
    rst           = 1'b0;
    check("t6_idle_after_rst", {31'd0, busy}, 32'd0);
    present(7, 0, 1'b0, 3'd4);
    clk_bringup(n);
    check("t6_gap_cleared_by_rst", n, 1);
    pre_and_go(4);
    send_beats(7, 2, 3'd4, -1);
    trail_post(1'b0, 2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
